// File: rtl/riscv_pkg.sv
// Shared decode-side types and constants for the integer pipeline.
package riscv_pkg;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND  = 4'd2;
    localparam logic [3:0] OR   = 4'd3;
    localparam logic [3:0] XOR  = 4'd4;
    localparam logic [3:0] SLL  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SLTU = 4'd7;
    localparam logic [3:0] SRA  = 4'd8;
    localparam logic [3:0] SLT  = 4'd9;

endpackage

// File: rtl/fwd_unit.sv
// Per-source forwarding mux: MEM beats WB beats register data; x0 never forwards.
module fwd_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_write,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_data,
    output logic            hit
);

    always_comb begin
        fwd_data = rs_data;
        hit      = 1'b0;
        // A load in MEM has no value yet; the hazard logic stalls instead.
        if (mem_reg_write && (mem_rd_addr == rs_addr) && (rs_addr != REG_ZERO) && !mem_is_load) begin
            fwd_data = mem_result;
            hit      = 1'b1;
        end else if (wb_reg_write && (wb_rd_addr == rs_addr) && (rs_addr != REG_ZERO)) begin
            fwd_data = wb_result;
            hit      = 1'b1;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use detection and ALU operand muxing.
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [4:0]            id_rs1_addr,
    input  logic [4:0]            id_rs2_addr,
    input  logic [4:0]            id_rd_addr,
    input  logic [1:0]            id_a_sel,
    input  logic                  id_b_sel,
    input  logic [ALU_CTRL_W-1:0] id_alu_control,
    input  logic                  id_reg_write,
    input  logic                  flush,
    input  logic [4:0]            mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic                  mem_is_load,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [4:0]            wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_result,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [ALU_CTRL_W-1:0] ALUcontrol,
    output logic [XLEN-1:0]       srcA,
    output logic [XLEN-1:0]       srcB,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_pc,
    output logic [4:0]            ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  load_use_stall
);

    logic                  occ;
    logic [XLEN-1:0]       pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]            rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [1:0]            a_sel_q;
    logic                  b_sel_q;
    logic [ALU_CTRL_W-1:0] alu_q;
    logic                  reg_write_q;

    logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
    logic                  hit_rs1, hit_rs2;
    logic                  rs1_used, hz, advance, capture;

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr       (rs1_addr_q),
        .rs_data       (rs1_data_q),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_is_load   (mem_is_load),
        .mem_result    (mem_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1),
        .hit           (hit_rs1)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr       (rs2_addr_q),
        .rs_data       (rs2_data_q),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_is_load   (mem_is_load),
        .mem_result    (mem_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2),
        .hit           (hit_rs2)
    );

    // rs2 always counts as a source because stores consume it as data.
    assign rs1_used = (a_sel_q == A_RS1);
    assign hz = occ & mem_is_load & mem_reg_write & (mem_rd_addr != REG_ZERO) &
                (((mem_rd_addr == rs1_addr_q) & rs1_used) | (mem_rd_addr == rs2_addr_q));

    assign load_use_stall = hz;
    assign ex_valid       = occ & ~hz;
    assign advance        = ex_valid & ex_ready;
    assign id_ready       = ~flush & (~occ | advance);
    assign capture        = id_valid & id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ         <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            a_sel_q     <= '0;
            b_sel_q     <= 1'b0;
            alu_q       <= '0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            occ <= 1'b0;
        end else if (capture) begin
            occ         <= 1'b1;
            pc_q        <= id_pc;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_addr_q  <= id_rs1_addr;
            rs2_addr_q  <= id_rs2_addr;
            rd_addr_q   <= id_rd_addr;
            a_sel_q     <= id_a_sel;
            b_sel_q     <= id_b_sel;
            alu_q       <= id_alu_control;
            reg_write_q <= id_reg_write;
        end else if (advance) begin
            occ <= 1'b0;
        end else if (occ) begin
            // Absorb forwarded values while held so a retiring WB write is not lost.
            if (hit_rs1) rs1_data_q <= fwd_rs1;
            if (hit_rs2) rs2_data_q <= fwd_rs2;
        end
    end

    always_comb begin
        case (a_sel_q)
            A_RS1:   srcA = fwd_rs1;
            A_PC:    srcA = pc_q;
            default: srcA = '0;
        endcase
    end

    assign srcB          = (b_sel_q == B_IMM) ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ALUcontrol    = alu_q;
    assign ex_pc         = pc_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q & ex_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected transfers queued by stimulus, popped by a monitor.
module tb_ex_operand_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [1:0]  id_a_sel;
    logic        id_b_sel;
    logic [3:0]  id_alu_control;
    logic        id_reg_write, flush;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, mem_is_load, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_ready, ex_valid;
    logic [3:0]  ALUcontrol;
    logic [31:0] srcA, srcB, ex_store_data, ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, load_use_stall;

    typedef struct {
        string       name;
        logic [31:0] a, b, st, pc;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    ex_operand_stage #(.XLEN(32), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .flush(flush),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ALUcontrol(ALUcontrol), .srcA(srcA), .srcB(srcB), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic [1:0] asel, input logic bsel,
                         input logic [3:0] alu, input logic rw);
        id_valid = 1'b1; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_a_sel = asel; id_b_sel = bsel; id_alu_control = alu; id_reg_write = rw;
    endtask

    task automatic expect_tx(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] st, input logic [31:0] pc, input logic [3:0] alu,
                             input logic [4:0] rd, input logic rw);
        exp_t e;
        e.name = name; e.a = a; e.b = b; e.st = st; e.pc = pc; e.alu = alu; e.rd = rd; e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"}, 32'(ex_valid), 32'd0);
        check({tag, ".srcA"}, srcA, 32'd0);
        check({tag, ".srcB"}, srcB, 32'd0);
        check({tag, ".store"}, ex_store_data, 32'd0);
        check({tag, ".alu"}, 32'(ALUcontrol), 32'd0);
        check({tag, ".pc"}, ex_pc, 32'd0);
        check({tag, ".rd"}, 32'(ex_rd_addr), 32'd0);
        check({tag, ".reg_write"}, 32'(ex_reg_write), 32'd0);
        check({tag, ".stall"}, 32'(load_use_stall), 32'd0);
    endtask

    // Monitor: every transfer downstream consumes exactly one expected entry.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got pc 0x%08h, required no transfer", ex_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".srcA"}, srcA, e.a);
                check({e.name, ".srcB"}, srcB, e.b);
                check({e.name, ".store"}, ex_store_data, e.st);
                check({e.name, ".pc"}, ex_pc, e.pc);
                check({e.name, ".alu"}, 32'(ALUcontrol), 32'(e.alu));
                check({e.name, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
                check({e.name, ".reg_write"}, 32'(ex_reg_write), 32'(e.rw));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_a_sel = '0; id_b_sel = 1'b0;
        id_alu_control = '0; id_reg_write = 1'b0;
        mem_rd_addr = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_result = '0;
        wb_rd_addr = '0; wb_reg_write = 1'b0; wb_result = '0;
        #2;
        check_all_zero("reset");
        step(); step();
        rst = 1'b0;

        // Basic pass-through
        step();
        drive(32'h100, 32'h10, 32'h20, 32'h5, 5'd1, 5'd2, 5'd3, 2'd0, 1'b0, ADD, 1'b1);
        expect_tx("basic", 32'h10, 32'h20, 32'h20, 32'h100, ADD, 5'd3, 1'b1);
        #1 check("basic.id_ready", 32'(id_ready), 32'd1);
        step();
        id_valid = 1'b0;
        check("basic.latency_valid", 32'(ex_valid), 32'd1);
        step();

        // MEM-over-WB priority, then refresh retains WB value
        ex_ready = 1'b0;
        drive(32'h200, 32'h55, 32'h66, 32'h77, 5'd5, 5'd6, 5'd8, 2'd0, 1'b1, SUB, 1'b1);
        step();
        id_valid = 1'b0;
        mem_rd_addr = 5'd5; mem_reg_write = 1'b1; mem_result = 32'hAAAA;
        wb_rd_addr = 5'd5; wb_reg_write = 1'b1; wb_result = 32'hBBBB;
        #1 check("prio.mem_wins", srcA, 32'hAAAA);
        check("prio.id_ready_held", 32'(id_ready), 32'd0);
        mem_reg_write = 1'b0;
        #1 check("prio.wb_next", srcA, 32'hBBBB);
        step();
        wb_reg_write = 1'b0;
        #1 check("prio.refreshed", srcA, 32'hBBBB);
        expect_tx("prio", 32'hBBBB, 32'h77, 32'h66, 32'h200, SUB, 5'd8, 1'b1);
        ex_ready = 1'b1;
        step();

        // x0 is never forwarded
        mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hDEAD;
        wb_rd_addr = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hBEEF;
        drive(32'h300, 32'h1111, 32'h2222, 32'h0, 5'd0, 5'd0, 5'd9, 2'd0, 1'b0, AND, 1'b0);
        expect_tx("x0", 32'h1111, 32'h2222, 32'h2222, 32'h300, AND, 5'd9, 1'b0);
        step();
        id_valid = 1'b0;
        step();
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Load-use stall on rs2, resolved via WB, surviving the refresh
        mem_rd_addr = 5'd7; mem_is_load = 1'b1; mem_reg_write = 1'b1; mem_result = 32'hFFFF;
        drive(32'h400, 32'h30, 32'h70, 32'h0, 5'd3, 5'd7, 5'd10, 2'd1, 1'b0, OR, 1'b1);
        step();
        drive(32'h500, 32'h44, 32'h55, 32'h99, 5'd4, 5'd5, 5'd11, 2'd2, 1'b1, XOR, 1'b1);
        #1 check("lu.ex_valid", 32'(ex_valid), 32'd0);
        check("lu.stall", 32'(load_use_stall), 32'd1);
        check("lu.id_ready", 32'(id_ready), 32'd0);
        check("lu.reg_write_gated", 32'(ex_reg_write), 32'd0);
        step();
        ex_ready = 1'b0;
        mem_is_load = 1'b0; mem_reg_write = 1'b0;
        wb_rd_addr = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h1234;
        #1 check("lu.resolved_valid", 32'(ex_valid), 32'd1);
        check("lu.srcB_fwd", srcB, 32'h1234);
        step();
        wb_reg_write = 1'b0;
        #1 check("lu.srcB_after_refresh", srcB, 32'h1234);
        expect_tx("loaduse", 32'h400, 32'h1234, 32'h1234, 32'h400, OR, 5'd10, 1'b1);
        ex_ready = 1'b1;
        #1 check("lu.id_ready_on_advance", 32'(id_ready), 32'd1);
        step();

        // Backpressure: instruction B held 3 cycles while C waits
        ex_ready = 1'b0;
        drive(32'h600, 32'hC1, 32'hC2, 32'h0, 5'd12, 5'd13, 5'd14, 2'd3, 1'b0, SRA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp.id_ready", 32'(id_ready), 32'd0);
            check("bp.pc_stable", ex_pc, 32'h500);
            check("bp.srcB_stable", srcB, 32'h99);
            step();
        end
        expect_tx("bp_B", 32'h0, 32'h99, 32'h55, 32'h500, XOR, 5'd11, 1'b1);
        expect_tx("bp_C", 32'h0, 32'hC2, 32'hC2, 32'h600, SRA, 5'd14, 1'b1);
        ex_ready = 1'b1;
        #1 check("bp.id_ready_release", 32'(id_ready), 32'd1);
        step();
        id_valid = 1'b0;
        #1 check("bp.no_bubble_valid", 32'(ex_valid), 32'd1);
        check("bp.no_bubble_pc", ex_pc, 32'h600);
        step();

        // Flush beats capture
        ex_ready = 1'b0;
        drive(32'h700, 32'hD1, 32'hD2, 32'h0, 5'd1, 5'd2, 5'd15, 2'd0, 1'b0, SLT, 1'b1);
        step();
        drive(32'h800, 32'hE1, 32'hE2, 32'h0, 5'd1, 5'd2, 5'd16, 2'd0, 1'b0, SLL, 1'b1);
        flush = 1'b1;
        #1 check("flush.id_ready", 32'(id_ready), 32'd0);
        step();
        flush = 1'b0; id_valid = 1'b0;
        #1 check("flush.ex_valid", 32'(ex_valid), 32'd0);
        check("flush.reg_write", 32'(ex_reg_write), 32'd0);
        step();
        check("flush.not_captured", 32'(ex_valid), 32'd0);

        // Asynchronous reset while holding a stalled instruction
        drive(32'h900, 32'hF1, 32'hF2, 32'h0, 5'd1, 5'd2, 5'd17, 2'd1, 1'b0, SRL, 1'b1);
        step();
        id_valid = 1'b0;
        #1 check("areset.held_valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("areset");
        step();
        rst = 1'b0;
        #1 check("areset.release_valid", 32'(ex_valid), 32'd0);
        drive(32'hA00, 32'hA1, 32'hA2, 32'h0, 5'd2, 5'd3, 5'd18, 2'd0, 1'b0, SLTU, 1'b1);
        expect_tx("post_reset", 32'hA1, 32'hA2, 32'hA2, 32'hA00, SLTU, 5'd18, 1'b1);
        ex_ready = 1'b1;
        step();
        id_valid = 1'b0;
        check("post_reset.valid", 32'(ex_valid), 32'd1);
        step();
        step();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
